fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Downstream consumer of the 8-deep byte FIFO: drains bytes through the FIFO read port (`rden`/`empty`/`dout`) and serializes each byte onto a UART TX line, 8N1 by default. It sits between the FIFO and the board TX pin. It issues exactly one read per frame and never reads while `empty` is high. It also provides a frame counter and a done strobe for status LEDs and debug.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `RD_LAT`, 1: FIFO read latency; `dout` is valid this many cycles after the `rden` cycle; legal range 1–3.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  when low, no new frame starts; a frame in flight completes.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_dout`  in  8  FIFO read data.
- `fifo_rden`  out  1  FIFO read strobe; one-cycle pulse per frame.
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high from the read request through the end of the stop bit.
- `tx_done`  out  1  one-cycle pulse in the last cycle of the stop bit.
- `frame_count`  out  16  frames completed since reset; wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, REQ, WAIT, START, DATA, PARITY (macro only), STOP.
- IDLE: `tx`=1, `busy`=0.
  - Go to REQ when `en`=1 and `fifo_empty`=0.
- REQ: one cycle with `fifo_rden`=1, then go to WAIT.
- WAIT: hold RD_LAT cycles.
  - In the last WAIT cycle, latch `fifo_dout` into the shift register.
  - Then go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - Bit index counter is 3 bits; leave DATA after bit 7.
- STOP: `tx`=1 for CLKS_PER_BIT cycles.
  - `tx_done` pulses in the final cycle.
  - `frame_count` increments by 1 on that same edge.
- After STOP:
  - If `en`=1 and `fifo_empty`=0, go directly to REQ.
  - Otherwise go to IDLE.
- `fifo_rden` is asserted only in REQ. REQ is entered only when `fifo_empty`=0 in the deciding cycle, so the block never reads an empty FIFO.
- Baud counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and reloads at each bit boundary.
- `en` falling mid-frame has no effect on the current frame. It only blocks the next REQ.
- `fifo_empty` toggling outside the deciding cycle is ignored.

## Timing
- Reset values: `tx`=1, `fifo_rden`=0, `busy`=0, `tx_done`=0, `frame_count`=0, state IDLE.
- Reset mid-frame: `tx` returns to 1 asynchronously. The partial byte is dropped; it is not re-read.
- Latency, with `rden` high in cycle n:
  - Data is sampled at the end of cycle n+RD_LAT.
  - `tx` falls at cycle n+RD_LAT+1.
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back frames: RD_LAT+1 idle-high cycles between the end of STOP and the next start bit (the REQ cycle plus the WAIT cycles).
- `busy` rises in the REQ cycle. It falls the cycle after the `tx_done` pulse, unless the next REQ follows immediately, in which case it stays high.

## Configuration
- `FIFO_UART_TX_PARITY_EN` defined:
  - PARITY state is inserted between DATA and STOP.
  - `tx` carries even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- Undefined: 8N1, with no PARITY state or logic.

## Test plan
- Reset: assert `reset` for 3 cycles.
  - Required: `tx`=1, `fifo_rden`=0, `busy`=0, `frame_count`=0 throughout.
- Single byte, CLKS_PER_BIT=4, RD_LAT=1: FIFO model holds 0xA5.
  - Required: one `rden` pulse.
  - Required: `tx` falls 2 cycles after `rden`.
  - Required: bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop.
  - Required: `tx_done` pulses once; `frame_count`=1.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C.
  - Required: three frames, each with a 2-cycle idle gap.
  - Required: exactly 3 `rden` pulses; no `rden` while `fifo_empty`=1; `frame_count`=3.
- `en` gating: drop `en` mid-frame of 0x55 while the FIFO still holds 0x66.
  - Required: 0x55 completes; no further `rden` until `en`=1.
  - Required: 0x66 then follows.
- Async reset mid-DATA of 0xF0.
  - Required: `tx`=1 in the same cycle as reset rises; the FSM is in IDLE.
  - Required: after release, the next FIFO byte is read and sent intact.
- `FIFO_UART_TX_PARITY_EN` defined, byte 0x07.
  - Required: parity bit = 1; frame length 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: one FIFO read per frame, 8N1 serialisation, frame counter.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rden,
    output logic        tx,
    output logic        busy,
    output logic        tx_done,
    output logic [15:0] frame_count
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] BaudPen  = CntW'(CLKS_PER_BIT - 2);
    localparam logic [1:0]      LatLast  = 2'(RD_LAT - 1);

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StReq, StWait, StStart, StData, StParity, StStop
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StReq, StWait, StStart, StData, StStop
    } state_e;
`endif

    state_e          state_q;
    logic [CntW-1:0] baud_q;
    logic [1:0]      lat_q;
    logic [2:0]      bit_q;
    logic [7:0]      data_q;
    logic [2:0]      bit_nxt;
    logic            start_req;

    assign bit_nxt   = bit_q + 3'd1;
    assign start_req = en && !fifo_empty;

    // All outputs are registered; each is loaded on the transition into the cycle it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            baud_q      <= '0;
            lat_q       <= '0;
            bit_q       <= '0;
            data_q      <= '0;
            tx          <= 1'b1;
            fifo_rden   <= 1'b0;
            busy        <= 1'b0;
            tx_done     <= 1'b0;
            frame_count <= '0;
        end else begin
            fifo_rden <= 1'b0;
            tx_done   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (start_req) begin
                        state_q   <= StReq;
                        fifo_rden <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                StReq: begin
                    state_q <= StWait;
                    lat_q   <= '0;
                end
                StWait: begin
                    if (lat_q == LatLast) begin
                        data_q  <= fifo_dout;
                        state_q <= StStart;
                        tx      <= 1'b0;
                        baud_q  <= '0;
                    end else begin
                        lat_q <= lat_q + 2'd1;
                    end
                end
                StStart: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= StData;
                        tx      <= data_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_q == BaudLast) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            state_q <= StParity;
                            tx      <= ^data_q;
`else
                            state_q <= StStop;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_nxt;
                            tx    <= data_q[bit_nxt];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                StParity: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        state_q <= StStop;
                        tx      <= 1'b1;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    // Raise tx_done so it lands in the final stop cycle.
                    if (baud_q == BaudPen) begin
                        tx_done     <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end
                    if (baud_q == BaudLast) begin
                        baud_q <= '0;
                        if (start_req) begin
                            state_q   <= StReq;
                            fifo_rden <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a pointer-based FIFO model and a per-bit frame model.
module tb_fifo_uart_tx;

    localparam int CPB    = 4;
    localparam int RD_LAT = 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        fifo_empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        fifo_rden;
    logic        tx;
    logic        busy;
    logic        tx_done;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_fc = 0;
    int last_len;
    logic last_par;

    // FIFO model: the initial block owns the write side, the always block the read side.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rden_cnt = 0;
    int rden_empty_err = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rden === 1'b1) begin
            rden_cnt <= rden_cnt + 1;
            if (wr_ptr == rd_ptr) begin
                rden_empty_err <= rden_empty_err + 1;
            end else begin
                fifo_dout <= mem[rd_ptr[5:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .RD_LAT      (RD_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rden  (fifo_rden),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done),
        .frame_count(frame_count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Expected line level for bit slot i of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_fc(input string name);
        n_cmp++;
        if (frame_count !== 16'(exp_fc)) begin
            n_err++;
            $display("FAIL %s frame_count: got %0d required %0d", name, frame_count, exp_fc);
        end
    endtask

    // Waits for the read strobe, then checks every cycle of WAIT and of the whole frame.
    task automatic check_frame(input logic [7:0] b, input bit immediate, input int drop_en_at,
                               input string name);
        int   waited;
        bit   seen;
        int   start_idx;
        int   done_idx;
        logic [3:0] got;
        logic [3:0] req;
        waited = 0;
        seen = 0;
        while (!seen && waited < 200) begin
            @(negedge clk);
            waited++;
            if (fifo_rden === 1'b1) seen = 1;
        end
        if (immediate) begin
            n_cmp++;
            if (waited != 1) begin
                n_err++;
                $display("FAIL %s gap: rden after %0d cycles, required 1", name, waited);
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: no rden within 200 cycles, required one", name);
            return;
        end
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s req cycle: tx=%b busy=%b required 1 1", name, tx, busy);
        end
        for (int j = 0; j < RD_LAT; j++) begin
            @(negedge clk);
            n_cmp++;
            if (tx !== 1'b1 || busy !== 1'b1 || fifo_rden !== 1'b0) begin
                n_err++;
                $display("FAIL %s wait cycle %0d: tx=%b busy=%b rden=%b required 1 1 0",
                         name, j, tx, busy, fifo_rden);
            end
        end
        start_idx = -1;
        done_idx = -1;
        for (int k = 0; k < NBITS * CPB; k++) begin
            @(negedge clk);
            if (k == drop_en_at) en = 1'b0;
            if (tx === 1'b0 && start_idx < 0) start_idx = k;
            if (tx_done === 1'b1 && done_idx < 0) done_idx = k;
            if (k == 9 * CPB + CPB / 2) last_par = tx;
            got = {tx, tx_done, busy, fifo_rden};
            req = {exp_bit(b, k / CPB), (k == NBITS * CPB - 1), 1'b1, 1'b0};
            n_cmp++;
            if (got !== req) begin
                n_err++;
                $display("FAIL %s byte %h cycle %0d: {tx,done,busy,rden}=%b required %b",
                         name, b, k, got, req);
            end
        end
        last_len = (start_idx >= 0 && done_idx >= 0) ? done_idx - start_idx + 1 : -1;
        exp_fc++;
        check_fc(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({tx, fifo_rden, busy, tx_done} !== 4'b1000 || frame_count !== 16'd0) begin
                n_err++;
                $display("FAIL reset cycle %0d: {tx,rden,busy,done}=%b fc=%0d required 1000 0",
                         i, {tx, fifo_rden, busy, tx_done}, frame_count);
            end
        end
        reset = 1'b0;
        exp_fc = 0;
    endtask

    task automatic test_single();
        int r0;
        r0 = rden_cnt;
        push(8'hA5);
        en = 1'b1;
        check_frame(8'hA5, 1'b0, -1, "single");
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || tx !== 1'b1 || rden_cnt - r0 != 1) begin
            n_err++;
            $display("FAIL single after: busy=%b tx=%b rden_pulses=%0d required 0 1 1",
                     busy, tx, rden_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        en = 1'b0;
        @(negedge clk);
        r0 = rden_cnt;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        en = 1'b1;
        check_frame(8'h00, 1'b0, -1, "b2b0");
        check_frame(8'hFF, 1'b1, -1, "b2b1");
        check_frame(8'h3C, 1'b1, -1, "b2b2");
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || rden_cnt - r0 != 3 || rden_empty_err != 0) begin
            n_err++;
            $display("FAIL b2b after: busy=%b rden_pulses=%0d empty_reads=%0d required 0 3 0",
                     busy, rden_cnt - r0, rden_empty_err);
        end
    endtask

    task automatic test_en_gating();
        int  r0;
        bit  bad;
        en = 1'b1;
        push(8'h55);
        push(8'h66);
        check_frame(8'h55, 1'b0, 5 * CPB + 1, "en_drop");
        r0 = rden_cnt;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_rden !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1;
        end
        n_cmp++;
        if (bad || rden_cnt != r0) begin
            n_err++;
            $display("FAIL en_gated idle: activity while en=0, rden_pulses=%0d required 0",
                     rden_cnt - r0);
        end
        en = 1'b1;
        check_frame(8'h66, 1'b0, -1, "en_resume");
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] nxt;
        int waited;
        nxt = 8'($urandom);
        en = 1'b1;
        push(8'hF0);
        push(nxt);
        waited = 0;
        while (fifo_rden !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        // Land inside data bit 1, which is low for 0xF0.
        repeat (RD_LAT + 2 * CPB + 1) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid pre: tx=%b required 0", tx);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rden !== 1'b0 || frame_count !== 16'd0) begin
            n_err++;
            $display("FAIL rst_mid async: tx=%b busy=%b rden=%b fc=%0d required 1 0 0 0",
                     tx, busy, fifo_rden, frame_count);
        end
        exp_fc = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_frame(nxt, 1'b0, -1, "rst_mid_next");
    endtask

    task automatic test_random();
        logic [7:0] b0;
        logic [7:0] b1;
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            push(b0);
            if (i[0]) push(b1);
            check_frame(b0, 1'b0, -1, "rand");
            if (i[0]) check_frame(b1, 1'b1, -1, "rand_b2b");
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        en = 1'b1;
        push(8'h07);
        check_frame(8'h07, 1'b0, -1, "parity");
        n_cmp++;
        if (last_par !== 1'b1 || last_len != 44) begin
            n_err++;
            $display("FAIL parity 0x07: bit=%b len=%0d required 1 44", last_par, last_len);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        n_cmp++;
        if (last_len != NBITS * CPB) begin
            n_err++;
            $display("FAIL frame_len: got %0d required %0d", last_len, NBITS * CPB);
        end
        test_back_to_back();
        test_en_gating();
        test_reset_mid_data();
        test_random();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        @(negedge clk);
        n_cmp++;
        if (rden_empty_err != 0 || rd_ptr != wr_ptr) begin
            n_err++;
            $display("FAIL fifo_final: empty_reads=%0d unread=%0d required 0 0",
                     rden_empty_err, wr_ptr - rd_ptr);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
